ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 72 +++++++
 tb/tb_ram_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: wait-state RAM slave with byte lanes, accept/complete pulses and an access counter.
module ram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        ram_hit1_o,
  output logic        ram_hit2_o,
  output logic        busy_o,
  output logic [31:0] access_cnt_o
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, DONE} state_t;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic we;
  logic [3:0] sel;
  logic [31:0] wdata, rdata;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic unused_addr;
  assign unused_addr = ^{ram_addr_i[31:DEPTH_LOG2+2], ram_addr_i[1:0]};
  always_comb begin
    state_nxt = state == IDLE   ? (ram_ce_i ? ACCEPT : IDLE) :
                state == ACCEPT ? (WAIT_CYCLES > 0 ? WAIT : DONE) :
                state == WAIT   ? (cnt == 4'd1 ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      access_cnt_o <= '0;
      idx          <= '0;
      we           <= 1'b0;
      sel          <= '0;
      wdata        <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ram_ce_i) begin
        idx   <= ram_addr_i[DEPTH_LOG2+1:2];
        we    <= ram_we_i;
        sel   <= ram_sel_i;
        wdata <= ram_data_i;
      end
      if (state == ACCEPT) cnt <= WAIT_LOAD;
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == DONE) access_cnt_o <= access_cnt_o + 32'd1;
    end
  end
  // Storage is never reset; the access fires only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst && state_nxt == DONE) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end else begin
        rdata <= mem[idx];
      end
    end
  end
  assign ram_hit1_o = state == ACCEPT;
  assign ram_hit2_o = state == DONE;
  assign busy_o     = state != IDLE;
  assign ram_data_o = (state == DONE && !we) ? rdata : '0;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: randomized checks of ram_responder against a word-array reference model.
module tb_ram_responder;
  localparam int W  = 2;
  localparam int DL = 10;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic ce = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] addr = 0, wd = 0, rd, cnt;
  logic hit1, hit2, busy;
  logic z_ce = 0, z_we = 0;
  logic [3:0] z_sel = 0;
  logic [31:0] z_addr = 0, z_wd = 0, z_rd, z_cnt;
  logic z_hit1, z_hit2, z_busy;
  int n_checks = 0, n_fail = 0;
  int exp_cnt = 0, z_exp_cnt = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] z_mem [int];

  ram_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .ram_ce_i(ce), .ram_we_i(we), .ram_sel_i(sel),
    .ram_addr_i(addr), .ram_data_i(wd), .ram_data_o(rd), .ram_hit1_o(hit1),
    .ram_hit2_o(hit2), .busy_o(busy), .access_cnt_o(cnt));

  ram_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ram_ce_i(z_ce), .ram_we_i(z_we), .ram_sel_i(z_sel),
    .ram_addr_i(z_addr), .ram_data_i(z_wd), .ram_data_o(z_rd), .ram_hit1_o(z_hit1),
    .ram_hit2_o(z_hit2), .busy_o(z_busy), .access_cnt_o(z_cnt));

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << DL));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic do_req(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int k;
    logic [31:0] exp_rd, old;
    k = widx(a);
    exp_rd = w ? 32'h0 : ref_mem[k];
    ce = 1; we = w; sel = s; addr = a; wd = d;
    @(posedge clk); #1;
    ce = 0; we = 1'($urandom); sel = 4'($urandom); addr = $urandom; wd = $urandom;
    for (int j = 1; j <= W + 2; j++) begin
      @(negedge clk);
      n_checks++;
      if (hit1 !== (j == 1)) begin n_fail++; $display("FAIL req_hit1 cycle %0d: got %b expected %b", j, hit1, j == 1); end
      n_checks++;
      if (hit2 !== (j == W + 2)) begin n_fail++; $display("FAIL req_hit2 cycle %0d: got %b expected %b", j, hit2, j == W + 2); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL req_busy cycle %0d: got %b expected 1", j, busy); end
      n_checks++;
      if (rd !== (j == W + 2 ? exp_rd : 32'h0)) begin
        n_fail++; $display("FAIL req_data cycle %0d addr %h: got %h expected %h", j, a, rd, j == W + 2 ? exp_rd : 32'h0);
      end
      if (j == W + 2) begin
        if (w) begin
          old = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
          ref_mem[k] = merge(old, d, s);
        end
        exp_cnt++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hit2 !== 1'b0) begin n_fail++; $display("FAIL req_idle: busy %b hit2 %b expected 0 0", busy, hit2); end
    n_checks++;
    if (cnt !== 32'(exp_cnt)) begin n_fail++; $display("FAIL req_count: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_reset;
    rst = 0; ce = 1; we = 1; sel = 4'hF; addr = 0; wd = $urandom;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({hit1, hit2, busy} !== 3'b000 || rd !== 0 || cnt !== 0) begin
        n_fail++; $display("FAIL reset_outputs: hit1 %b hit2 %b busy %b data %h cnt %h expected all 0", hit1, hit2, busy, rd, cnt);
      end
    end
    ce = 0; rst = 1; exp_cnt = 0; z_exp_cnt = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || z_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b busy0 %b expected 0 0", busy, z_busy); end
  endtask

  task automatic test_directed;
    do_req(1, 4'hF, 32'h10, 32'hDEADBEEF);
    do_req(0, 4'hF, 32'h10, 32'h0);
    do_req(0, 4'h3, 32'h1010, 32'h0);
    do_req(1, 4'b0001, 32'h10, 32'h000000AA);
    do_req(0, 4'h0, 32'h13, 32'h0);
    do_req(1, 4'b0000, 32'h10, $urandom);
    do_req(0, 4'hF, 32'h10, 32'h0);
  endtask

  task automatic test_back_to_back;
    int n1, n2, last;
    rst = 0;
    @(negedge clk);
    rst = 1; exp_cnt = 0; z_exp_cnt = 0;
    ce = 1; we = 0; sel = 4'($urandom); addr = 32'h10 | 32'($urandom_range(0, 3)); wd = $urandom;
    n1 = 0; n2 = 0; last = 0;
    for (int c = 1; c <= 3 * (W + 3) + 2; c++) begin
      @(negedge clk);
      if (hit1) begin n1++; if (n1 == 3) ce = 0; end
      if (hit2) begin
        n2++;
        n_checks++;
        if (rd !== ref_mem[4]) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", rd, ref_mem[4]); end
        if (n2 > 1) begin
          n_checks++;
          if (c - last !== W + 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", c - last, W + 3); end
        end
        last = c;
      end
    end
    exp_cnt = 3;
    n_checks++;
    if (n1 !== 3 || n2 !== 3) begin n_fail++; $display("FAIL b2b_pulses: hit1 %0d hit2 %0d expected 3 3", n1, n2); end
    n_checks++;
    if (cnt !== 32'd3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", cnt); end
  endtask

  task automatic test_abort;
    ce = 1; we = 1; sel = 4'hF; addr = 32'h10; wd = 32'h12345678;
    @(posedge clk); #1;
    ce = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    n_checks++;
    if ({hit1, hit2, busy} !== 3'b000 || rd !== 0 || cnt !== 0) begin
      n_fail++; $display("FAIL abort_outputs: hit1 %b hit2 %b busy %b data %h cnt %h expected all 0", hit1, hit2, busy, rd, cnt);
    end
    exp_cnt = 0; z_exp_cnt = 0;
    @(negedge clk);
    rst = 1;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (hit2 !== 1'b0) begin n_fail++; $display("FAIL abort_no_hit2: got %b expected 0", hit2); end
    end
    do_req(0, 4'hF, 32'h10, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] idxs [6];
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      idxs[i] = 32'($urandom_range(0, (1 << DL) - 1));
      do_req(1, 4'hF, (idxs[i] << 2) | ($urandom & ~32'hFFF), $urandom);
    end
    for (int i = 0; i < 30; i++) begin
      a = ($urandom & ~32'hFFC) | (idxs[$urandom_range(0, 5)] << 2);
      do_req(1'($urandom), 4'($urandom), a, $urandom);
    end
    for (int i = 0; i < 6; i++) do_req(0, 4'($urandom), idxs[i] << 2, 32'h0);
  endtask

  task automatic test_zero_wait;
    logic [31:0] a, d, exp_rd;
    int k;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      k = widx(a);
      d = $urandom;
      z_we = (i % 2 == 0);
      if (!z_we) a = 32'(k << 2) | ($urandom & ~32'hFFF);
      if (z_we) a = 32'(k << 2) + 32'(i << 20);
      if (!z_we) a = z_addr ^ 32'h0010_0003;
      k = widx(a);
      exp_rd = z_we ? 32'h0 : z_mem[k];
      z_ce = 1; z_sel = 4'hF; z_addr = a; z_wd = d;
      @(posedge clk); #1;
      z_ce = 0; z_we = ~z_we; z_addr = $urandom; z_wd = $urandom;
      @(negedge clk);
      n_checks++;
      if ({z_hit1, z_hit2, z_busy} !== 3'b101) begin n_fail++; $display("FAIL zw_accept: hit1/hit2/busy got %b expected 101", {z_hit1, z_hit2, z_busy}); end
      @(negedge clk);
      n_checks++;
      if ({z_hit1, z_hit2, z_busy} !== 3'b011) begin n_fail++; $display("FAIL zw_done: hit1/hit2/busy got %b expected 011", {z_hit1, z_hit2, z_busy}); end
      n_checks++;
      if (z_rd !== exp_rd) begin n_fail++; $display("FAIL zw_data addr %h: got %h expected %h", a, z_rd, exp_rd); end
      if (i % 2 == 0) z_mem[k] = d;
      z_exp_cnt++;
      @(negedge clk);
      n_checks++;
      if (z_busy !== 1'b0 || z_cnt !== 32'(z_exp_cnt)) begin
        n_fail++; $display("FAIL zw_idle: busy %b cnt %0d expected 0 %0d", z_busy, z_cnt, z_exp_cnt);
      end
      z_we = (i % 2 == 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_random();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
